// File: rtl/load_pkg.sv
// ----------------------------------------------------------------------------
// load_pkg
// Shared types and helpers for the load alignment path.
//   load_funct3_e : RISC-V load encodings (LB..LWU); 3'b111 is not a legal load
//   state_e       : sequencing states of load_align_unit
//   size_bytes()  : access size in bytes for a funct3 at a given XLEN. Encodings
//                   that are not legal at that XLEN (LD/LWU at 32, 3'b111)
//                   resolve to a full-word access.
// ----------------------------------------------------------------------------
package load_pkg;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LD  = 3'b011,
      LBU = 3'b100,
      LHU = 3'b101,
      LWU = 3'b110
   } load_funct3_e;

   typedef enum logic [2:0] {
      IDLE,
      REQ0,
      WAIT0,
      REQ1,
      WAIT1,
      RESP
   } state_e;

   // LWU is 4 bytes everywhere: at XLEN=32 the full word is also 4 bytes.
   // LD and the unused encoding both mean "one full word".
   function automatic logic [3:0] size_bytes(input logic [2:0] funct3, input int xlen);
      case (funct3)
         LB, LBU:  size_bytes = 4'd1;
         LH, LHU:  size_bytes = 4'd2;
         LW, LWU:  size_bytes = 4'd4;
         default:  size_bytes = (xlen == 64) ? 4'd8 : 4'd4;
      endcase
   endfunction

endpackage

// File: rtl/load_extend.sv
// ----------------------------------------------------------------------------
// load_extend
// Combinational sign/zero extender for right-aligned load data.
// Parameters:
//   XLEN   : data width (32 or 64)
// Ports:
//   funct3 : in  [2:0]      load type
//   data   : in  [XLEN-1:0] right-aligned raw load bytes
//   result : out [XLEN-1:0] extended register-file value
// Encodings that are not legal at this XLEN pass the word through unchanged.
// ----------------------------------------------------------------------------
module load_extend
   import load_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] data,
   output logic [XLEN-1:0] result
);

   // Size casts of signed slices sign-extend; unsigned slices zero-extend.
   // At XLEN=32 the LW and LWU arms collapse to a plain pass-through.
   always_comb begin
      result = data;
      case (funct3)
         LB:      result = XLEN'($signed(data[7:0]));
         LH:      result = XLEN'($signed(data[15:0]));
         LW:      result = XLEN'($signed(data[31:0]));
         LBU:     result = XLEN'(data[7:0]);
         LHU:     result = XLEN'(data[15:0]);
         LWU:     result = XLEN'(data[31:0]);
         default: result = data;
      endcase
   end

endmodule

// File: rtl/load_align_unit.sv
// ----------------------------------------------------------------------------
// load_align_unit
// Sequential load path between the LSU and data memory. Accepts one load,
// issues one or two word-aligned reads, right-aligns the bytes and
// sign/zero-extends them into a register-file value.
// Parameters:
//   XLEN : word width, 32 or 64
//   AW   : byte-address width
// Ports:
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_flush                 : abort the in-flight load
//   i_req_valid/o_req_ready : load request handshake (i_addr, i_funct3)
//   o_mem_req_valid/i_mem_req_ready, o_mem_addr : word-aligned read request
//   i_mem_rsp_valid/i_mem_rsp_data              : read response
//   o_rsp_valid/o_rsp_data  : one-cycle result pulse
//   o_misaligned            : one-cycle pulse for a word-crossing load when
//                             splitting is not built in
// Configuration:
//   MISALIGN_SPLIT_EN : when defined, word-crossing loads are served with two
//                       reads; otherwise they raise o_misaligned and never
//                       touch memory.
// ----------------------------------------------------------------------------
module load_align_unit
   import load_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int AW   = 32
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_flush,
   input  logic            i_req_valid,
   output logic            o_req_ready,
   input  logic [AW-1:0]   i_addr,
   input  logic [2:0]      i_funct3,
   output logic            o_mem_req_valid,
   input  logic            i_mem_req_ready,
   output logic [AW-1:0]   o_mem_addr,
   input  logic            i_mem_rsp_valid,
   input  logic [XLEN-1:0] i_mem_rsp_data,
   output logic            o_rsp_valid,
   output logic [XLEN-1:0] o_rsp_data,
   output logic            o_misaligned
);

   localparam int NBYTES = XLEN / 8;
   localparam int OFFW   = $clog2(NBYTES);

   state_e            state;
   logic [AW-1:0]     base;
   logic [2:0]        funct3_q;
   logic [OFFW-1:0]   offset_q;
   logic              split_q;
   logic [XLEN-1:0]   lo_buf;
   logic [XLEN-1:0]   hi_buf;
   logic [1:0]        outstanding;

   logic [OFFW-1:0]   req_offset;
   logic [4:0]        req_end;
   logic              req_split;
   logic [AW-1:0]     word_addr;
   logic              accept;
   logic              mem_hs;
   logic              rsp_owed;
   logic [2*XLEN-1:0] merged;
   logic [XLEN-1:0]   aligned;
   logic [XLEN-1:0]   extended;

   // Request decode: a load is split when its last byte lies past the end of
   // the word containing its first byte.
   assign req_offset = i_addr[OFFW-1:0];
   assign req_end    = 5'(req_offset) + 5'(size_bytes(i_funct3, XLEN));
   assign req_split  = req_end > 5'(NBYTES);
   assign word_addr  = {i_addr[AW-1:OFFW], OFFW'(0)};

   assign accept   = i_req_valid && o_req_ready;
   assign mem_hs   = o_mem_req_valid && i_mem_req_ready;
   assign rsp_owed = i_mem_rsp_valid && (outstanding != 2'd0);

   // A new load waits until every read issued so far (including reads of a
   // flushed load) has returned, so stale data can never be mistaken for ours.
   assign o_req_ready = (state == IDLE) && (outstanding == 2'd0);

   // The result is formed in the same cycle the last word arrives, so the
   // arriving word is merged directly instead of from its buffer. hi_buf is
   // cleared on accept, which keeps the upper half zero for single-read loads.
   always_comb begin
      merged = {hi_buf, i_mem_rsp_data};
      if (state == WAIT1) begin
         merged = {i_mem_rsp_data, lo_buf};
      end
      aligned = XLEN'(merged >> {offset_q, 3'b000});
   end

   load_extend #(
      .XLEN (XLEN)
   ) u_extend (
      .funct3 (funct3_q),
      .data   (aligned),
      .result (extended)
   );

   // Outstanding-read counter: counts accepted memory requests and retires one
   // per response, whether the response is consumed or dropped after a flush.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         outstanding <= 2'd0;
      end else begin
         outstanding <= outstanding + 2'(mem_hs) - 2'(rsp_owed);
      end
   end

   // Main sequencer with registered outputs. Reset beats flush; flush drops
   // the in-flight load from any state without producing a response.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state           <= IDLE;
         o_mem_req_valid <= 1'b0;
         o_mem_addr      <= '0;
         o_rsp_valid     <= 1'b0;
         o_rsp_data      <= '0;
         o_misaligned    <= 1'b0;
         lo_buf          <= '0;
         hi_buf          <= '0;
         base            <= '0;
         funct3_q        <= 3'b000;
         offset_q        <= '0;
         split_q         <= 1'b0;
      end else if (i_flush) begin
         state           <= IDLE;
         o_mem_req_valid <= 1'b0;
         o_rsp_valid     <= 1'b0;
         o_misaligned    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  base     <= word_addr;
                  funct3_q <= i_funct3;
                  offset_q <= req_offset;
                  split_q  <= req_split;
                  hi_buf   <= '0;
`ifdef MISALIGN_SPLIT_EN
                  state           <= REQ0;
                  o_mem_req_valid <= 1'b1;
                  o_mem_addr      <= word_addr;
`else
                  if (req_split) begin
                     state        <= RESP;
                     o_misaligned <= 1'b1;
                  end else begin
                     state           <= REQ0;
                     o_mem_req_valid <= 1'b1;
                     o_mem_addr      <= word_addr;
                  end
`endif
               end
            end
            REQ0: begin
               if (mem_hs) begin
                  o_mem_req_valid <= 1'b0;
                  state           <= WAIT0;
               end
            end
            WAIT0: begin
               if (i_mem_rsp_valid) begin
                  lo_buf <= i_mem_rsp_data;
                  if (split_q) begin
                     state           <= REQ1;
                     o_mem_req_valid <= 1'b1;
                     o_mem_addr      <= base + AW'(NBYTES);
                  end else begin
                     state       <= RESP;
                     o_rsp_valid <= 1'b1;
                     o_rsp_data  <= extended;
                  end
               end
            end
            REQ1: begin
               if (mem_hs) begin
                  o_mem_req_valid <= 1'b0;
                  state           <= WAIT1;
               end
            end
            WAIT1: begin
               if (i_mem_rsp_valid) begin
                  hi_buf      <= i_mem_rsp_data;
                  state       <= RESP;
                  o_rsp_valid <= 1'b1;
                  o_rsp_data  <= extended;
               end
            end
            RESP: begin
               o_rsp_valid  <= 1'b0;
               o_misaligned <= 1'b0;
               state        <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
